// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types for the branch predictor update controller.
package bpu_pkg;
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        is_branch;
    } upd_t;
    localparam logic [1:0] BHT_CLR = 2'b00;
endpackage

// File: rtl/bpu_upd_fifo.sv
// bpu_upd_fifo: 2-push / 1-pop update FIFO; push A lands ahead of push B.
module bpu_upd_fifo
    import bpu_pkg::*;
#(
    parameter int QDEPTH = 4,
    localparam int AW = $clog2(QDEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_push_a,
    input  upd_t        i_data_a,
    input  logic        i_push_b,
    input  upd_t        i_data_b,
    input  logic        i_pop,
    output upd_t        o_head,
    output logic        o_empty,
    output logic [AW:0] o_free
);
    upd_t        r_mem [QDEPTH];
    logic [AW:0] r_wptr, r_rptr, w_wptr_b;

    assign w_wptr_b = r_wptr + {{AW{1'b0}}, i_push_a};
    assign o_empty  = r_wptr == r_rptr;
    assign o_free   = (AW+1)'(QDEPTH) - (r_wptr - r_rptr);
    assign o_head   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= w_wptr_b + {{AW{1'b0}}, i_push_b};
            r_rptr <= r_rptr + {{AW{1'b0}}, i_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (i_push_a) r_mem[r_wptr[AW-1:0]] <= i_data_a;
        if (i_push_b) r_mem[w_wptr_b[AW-1:0]] <= i_data_b;
    end
endmodule

// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl: serializes predictor table writes; clear sweep after reset/flush,
// then drains merged EX/ID resolve updates through a small FIFO.
module bpu_update_ctrl
    import bpu_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int NENT   = 256,
    parameter int IDX_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush_req,
    input  logic             i_id_upd_valid,
    input  logic [31:0]      i_id_upd_pc,
    input  logic [31:0]      i_id_upd_target,
    input  logic             i_id_upd_taken,
    input  logic             i_id_upd_is_branch,
    input  logic             i_ex_upd_valid,
    input  logic [31:0]      i_ex_upd_pc,
    input  logic [31:0]      i_ex_upd_target,
    output logic             o_wr_valid,
    output logic             o_wr_init,
    output logic [IDX_W-1:0] o_wr_index,
    output logic [31:0]      o_wr_pc,
    output logic [31:0]      o_wr_target,
    output logic             o_wr_taken,
    output logic             o_wr_is_branch,
    output logic             o_pred_enable,
    output logic [15:0]      o_drop_cnt
);
    localparam int AW = $clog2(QDEPTH);

    state_e           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_sweep, w_idx;
    logic             w_init_wr, w_run, w_push_ex, w_push_id, w_empty;
    logic [AW:0]      w_free;
    logic [1:0]       w_drop;
    logic [16:0]      w_drop_sum;
    upd_t             w_head, w_ex, w_id;

    assign w_ex = '{pc: i_ex_upd_pc, target: i_ex_upd_target, taken: 1'b1, is_branch: 1'b0};
    assign w_id = '{pc: i_id_upd_pc, target: i_id_upd_target, taken: i_id_upd_taken,
                    is_branch: i_id_upd_is_branch};
    assign w_drop_sum = {1'b0, o_drop_cnt} + {15'd0, w_drop};

    // Free slots are taken before this edge's pop; EX is older so it claims a slot first.
    always_comb begin
        w_init_wr   = i_flush_req || r_state == ST_INIT;
        w_run       = !w_init_wr;
        w_idx       = i_flush_req ? '0 : r_sweep;
        w_state_nxt = (w_init_wr && w_idx != IDX_W'(NENT-1)) ? ST_INIT : ST_RUN;
        w_push_ex   = w_run && i_ex_upd_valid && w_free != '0;
        w_push_id   = w_run && i_id_upd_valid && w_free > (AW+1)'(i_ex_upd_valid);
        w_drop      = w_run ? {1'b0, i_ex_upd_valid && !w_push_ex} + {1'b0, i_id_upd_valid && !w_push_id}
                            : 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep        <= '0;
            o_wr_valid     <= 1'b0;
            o_wr_init      <= 1'b0;
            o_wr_index     <= '0;
            o_wr_pc        <= '0;
            o_wr_target    <= '0;
            o_wr_taken     <= 1'b0;
            o_wr_is_branch <= 1'b0;
            o_pred_enable  <= 1'b0;
            o_drop_cnt     <= '0;
        end else if (w_init_wr) begin
            r_sweep        <= w_idx + 1'b1;
            o_wr_valid     <= 1'b1;
            o_wr_init      <= 1'b1;
            o_wr_index     <= w_idx;
            o_wr_pc        <= '0;
            o_wr_target    <= '0;
            {o_wr_taken, o_wr_is_branch} <= BHT_CLR;
            o_pred_enable  <= 1'b0;
        end else begin
            o_wr_valid     <= !w_empty;
            o_wr_init      <= 1'b0;
            o_pred_enable  <= 1'b1;
            o_drop_cnt     <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (!w_empty) begin
                o_wr_index     <= w_head.pc[IDX_W+1:2];
                o_wr_pc        <= w_head.pc;
                o_wr_target    <= w_head.target;
                o_wr_taken     <= w_head.taken;
                o_wr_is_branch <= w_head.is_branch;
            end
        end
    end

    bpu_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (i_flush_req),
        .i_push_a (w_push_ex),
        .i_data_a (w_ex),
        .i_push_b (w_push_id),
        .i_data_b (w_id),
        .i_pop    (w_run && !w_empty),
        .o_head   (w_head),
        .o_empty  (w_empty),
        .o_free   (w_free)
    );
endmodule

// File: tb/tb_bpu_update_ctrl.sv
// tb_bpu_update_ctrl: scoreboard bench; a queue-based reference model predicts every write.
module tb_bpu_update_ctrl;
    localparam int NENT = 256;
    localparam int QD   = 4;

    logic        clk = 1'b0, rst_n = 1'b1, flush_req = 1'b0;
    logic        id_v = 1'b0, id_tk = 1'b0, id_br = 1'b0, ex_v = 1'b0;
    logic [31:0] id_pc = '0, id_tg = '0, ex_pc = '0, ex_tg = '0;
    logic        wr_valid, wr_init, wr_taken, wr_is_branch, pred_enable;
    logic [7:0]  wr_index;
    logic [31:0] wr_pc, wr_target;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    bpu_update_ctrl #(.QDEPTH(QD), .NENT(NENT), .IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush_req(flush_req),
        .i_id_upd_valid(id_v), .i_id_upd_pc(id_pc), .i_id_upd_target(id_tg),
        .i_id_upd_taken(id_tk), .i_id_upd_is_branch(id_br),
        .i_ex_upd_valid(ex_v), .i_ex_upd_pc(ex_pc), .i_ex_upd_target(ex_tg),
        .o_wr_valid(wr_valid), .o_wr_init(wr_init), .o_wr_index(wr_index),
        .o_wr_pc(wr_pc), .o_wr_target(wr_target), .o_wr_taken(wr_taken),
        .o_wr_is_branch(wr_is_branch), .o_pred_enable(pred_enable), .o_drop_cnt(drop_cnt)
    );

    typedef struct {
        bit v; bit init; bit [7:0] idx; bit [31:0] pc; bit [31:0] tgt; bit tk; bit br;
    } exp_t;

    exp_t sbq[$];
    exp_t mq[$];
    int   checks = 0, errors = 0;
    bit   m_init = 1'b1, m_pe = 1'b0;
    int   m_sweep = 0, m_drop = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk_upd(bit [31:0] pc, bit [31:0] tgt, bit tk, bit br);
        exp_t e;
        e.v = 1; e.init = 0; e.idx = 8'((pc / 4) % NENT); e.pc = pc; e.tgt = tgt; e.tk = tk; e.br = br;
        return e;
    endfunction

    // Reference: clear sweep, or pop-then-append with slots counted before the pop.
    task automatic model(bit fl);
        exp_t e;
        int   idx, free;
        e = '{default: 0};
        if (fl || m_init) begin
            idx = fl ? 0 : m_sweep;
            e.v = 1; e.init = 1; e.idx = 8'(idx);
            mq.delete();
            m_sweep = idx + 1;
            m_init  = (idx != NENT - 1);
            m_pe    = 0;
        end else begin
            free = QD - mq.size();
            if (mq.size() > 0) e = mq.pop_front();
            if (ex_v) begin
                if (free > 0) begin mq.push_back(mk_upd(ex_pc, ex_tg, 1, 0)); free--; end
                else m_drop++;
            end
            if (id_v) begin
                if (free > 0) begin mq.push_back(mk_upd(id_pc, id_tg, id_tk, id_br)); free--; end
                else m_drop++;
            end
            if (m_drop > 65535) m_drop = 65535;
            m_pe = 1;
        end
        sbq.push_back(e);
    endtask

    task automatic step(bit fl, bit ev, bit [31:0] ep, bit [31:0] et,
                        bit iv, bit [31:0] ip, bit [31:0] it, bit itk, bit ibr);
        @(negedge clk);
        #2;
        flush_req = fl; ex_v = ev; ex_pc = ep; ex_tg = et;
        id_v = iv; id_pc = ip; id_tg = it; id_tk = itk; id_br = ibr;
        model(fl);
        @(posedge clk);
        #1;
        chk("pred_enable", 64'(pred_enable), 64'(m_pe));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        flush_req = 0; ex_v = 0; id_v = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_wr_valid"}, 64'(wr_valid), 0);
        chk({tag, "_wr_init"}, 64'(wr_init), 0);
        chk({tag, "_wr_index"}, 64'(wr_index), 0);
        chk({tag, "_pred_enable"}, 64'(pred_enable), 0);
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (wr_valid !== e.v || (e.v && ({wr_init, wr_index, wr_pc, wr_target, wr_taken, wr_is_branch}
                    !== {e.init, e.idx, e.pc, e.tgt, e.tk, e.br}))) begin
                errors++;
                $display("FAIL wr_port actual v=%0b init=%0b idx=%0h pc=%h tgt=%h tk=%0b br=%0b required v=%0b init=%0b idx=%0h pc=%h tgt=%h tk=%0b br=%0b",
                         wr_valid, wr_init, wr_index, wr_pc, wr_target, wr_taken, wr_is_branch,
                         e.v, e.init, e.idx, e.pc, e.tgt, e.tk, e.br);
            end
        end
    end

    initial begin
        #3 rst_n = 0;
        #1 chk_zero("reset");
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < NENT; i++) begin
            step(0, 1, 32'h4000 + 32'(i) * 4, 32'h10, 1, 32'h8000, 32'h20, 1, 1);
            chk("init_no_pred", 64'(pred_enable), 0);
        end
        idle();
        chk("pred_rise", 64'(pred_enable), 1);

        step(0, 0, 0, 0, 1, 32'h100, 32'h80, 1, 1);
        chk("lat_edge_k", 64'(wr_valid), 0);
        idle();
        chk("lat_valid", 64'(wr_valid), 1);
        chk("lat_index", 64'(wr_index), 64'h40);
        chk("lat_pc", 64'(wr_pc), 64'h100);
        chk("lat_target", 64'(wr_target), 64'h80);
        idle();
        chk("lat_after", 64'(wr_valid), 0);

        step(0, 1, 32'h200, 32'h1234, 1, 32'h300, 32'h5678, 0, 1);
        idle();
        chk("dual_first_pc", 64'(wr_pc), 64'h200);
        chk("dual_first_tk_br", 64'({wr_taken, wr_is_branch}), 64'b10);
        idle();
        chk("dual_second_pc", 64'(wr_pc), 64'h300);
        idle();

        for (int i = 0; i < 3; i++)
            step(0, 1, $urandom, $urandom, 1, $urandom, $urandom, 1'($urandom), 1'($urandom));
        repeat (6) idle();
        chk("fill_drops", 64'(drop_cnt), 1);

        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        for (int i = 0; i < NENT + 2 && m_init; i++) idle();
        repeat (6) idle();

        step(0, 1, 32'hA00, 32'h1, 1, 32'hB00, 32'h2, 1, 1);
        step(0, 1, 32'hC00, 32'h3, 1, 32'hD00, 32'h4, 0, 1);
        step(1, 1, 32'hE00, 32'h5, 1, 32'hF00, 32'h6, 1, 1);
        chk("flush_init", 64'(wr_init), 1);
        chk("flush_index", 64'(wr_index), 0);
        chk("flush_pred", 64'(pred_enable), 0);
        for (int i = 1; i < NENT; i++) idle();
        idle();
        chk("flush_pred_back", 64'(pred_enable), 1);

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 100; i++) idle();
        chk("pre_rst_index", 64'(wr_index), 100);
        @(negedge clk);
        #2 rst_n = 0;
        #1 chk_zero("midsweep_rst");
        sbq.delete(); mq.delete();
        m_init = 1; m_sweep = 0; m_drop = 0; m_pe = 0;
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        idle();
        chk("rst_restart_index", 64'(wr_index), 0);
        repeat (3) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
